tc_phase_scheduler: RTL and testbench

- Sequences a two-road intersection through six registered phases: NS green, NS yellow, all-red, EW green, EW yellow, all-red.
- Phase durations are programmable and counted in tick enables.
- Holds NS green while no EW demand is present.
- Latches pedestrian walk requests and serves each one on the next green of the matching direction.
- Sits between the tick prescaler and the lamp drivers, and replaces the hard-wired 6-2-3-2 sequencing of the existing controller.

---
 rtl/tc_pkg.sv | 43 ++++
 rtl/tc_phase_timer.sv | 33 +++
 rtl/tc_phase_scheduler.sv | 148 ++++++++++++++
 tb/tb_tc_phase_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the two-road phase scheduler: phase codes,
// default phase durations and the lamp decode used by the lamp drivers.
package tc_pkg;

    typedef enum logic [2:0] {
        PH_NSG = 3'd0,
        PH_NSY = 3'd1,
        PH_AR1 = 3'd2,
        PH_EWG = 3'd3,
        PH_EWY = 3'd4,
        PH_AR2 = 3'd5
    } phase_e;

    localparam int DEF_NSG_TICKS = 6;
    localparam int DEF_EWG_TICKS = 3;
    localparam int DEF_Y_TICKS   = 2;
    localparam int DEF_AR_TICKS  = 1;
    localparam int DEF_TW        = 4;

    typedef struct packed {
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic ew_g;
        logic ew_y;
        logic ew_r;
    } lamps_t;

    // Unknown codes decode to all-red so a corrupted phase never shows a conflicting green.
    function automatic lamps_t lamp_vec(input phase_e ph);
        lamps_t l;
        l = '0;
        case (ph)
            PH_NSG:  begin l.ns_g = 1'b1; l.ew_r = 1'b1; end
            PH_NSY:  begin l.ns_y = 1'b1; l.ew_r = 1'b1; end
            PH_EWG:  begin l.ns_r = 1'b1; l.ew_g = 1'b1; end
            PH_EWY:  begin l.ns_r = 1'b1; l.ew_y = 1'b1; end
            default: begin l.ns_r = 1'b1; l.ew_r = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tc_phase_timer.sv
// Phase down-counter: loaded with duration-1 on phase entry, decrements on tick,
// saturates at zero; hold suppresses expire so the current phase can be extended.
module tc_phase_timer
    import tc_pkg::*;
#(
    parameter int             TW        = DEF_TW,
    parameter logic [TW-1:0]  RESET_VAL = '0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    input  logic          hold,
    output logic          expire
);

    logic [TW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count_q <= RESET_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign expire = tick && (count_q == '0) && !hold;

endmodule

// File: rtl/tc_phase_scheduler.sv
// Six-phase two-road intersection scheduler with programmable durations,
// EW demand hold and pedestrian walk latches (pedestrian logic under TC_PED_EN).
module tc_phase_scheduler
    import tc_pkg::*;
#(
    parameter int NSG_TICKS = DEF_NSG_TICKS,
    parameter int EWG_TICKS = DEF_EWG_TICKS,
    parameter int Y_TICKS   = DEF_Y_TICKS,
    parameter int AR_TICKS  = DEF_AR_TICKS,
    parameter int TW        = DEF_TW
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       tick,
    input  logic       sensor,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic       NS_G,
    output logic       NS_Y,
    output logic       NS_R,
    output logic       EW_G,
    output logic       EW_Y,
    output logic       EW_R,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase,
    output logic       phase_start
);

    localparam logic [TW-1:0] NSG_LD = TW'(NSG_TICKS - 1);
    localparam logic [TW-1:0] EWG_LD = TW'(EWG_TICKS - 1);
    localparam logic [TW-1:0] Y_LD   = TW'(Y_TICKS - 1);
    localparam logic [TW-1:0] AR_LD  = TW'(AR_TICKS - 1);

    phase_e        phase_q, phase_d;
    lamps_t        lamps_q;
    logic          start_q;
    logic          advance;
    logic          expire;
    logic          hold;
    logic          demand;
    logic [TW-1:0] load_val;

`ifdef TC_PED_EN
    logic pend_ns_q, pend_ew_q;
    logic walk_ns_q, walk_ew_q;
    logic enter_ns, enter_ew, leave_ns, leave_ew;

    assign enter_ns = advance && (phase_d == PH_NSG);
    assign enter_ew = advance && (phase_d == PH_EWG);
    assign leave_ns = advance && (phase_q == PH_NSG);
    assign leave_ew = advance && (phase_q == PH_EWG);

    // A request coinciding with its green entry is served on that edge instead of pending.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            walk_ns_q <= 1'b0;
            walk_ew_q <= 1'b0;
        end else begin
            if (enter_ns) begin
                walk_ns_q <= pend_ns_q | ped_req_ns;
                pend_ns_q <= 1'b0;
            end else begin
                pend_ns_q <= pend_ns_q | ped_req_ns;
                if (leave_ns) walk_ns_q <= 1'b0;
            end
            if (enter_ew) begin
                walk_ew_q <= pend_ew_q | ped_req_ew;
                pend_ew_q <= 1'b0;
            end else begin
                pend_ew_q <= pend_ew_q | ped_req_ew;
                if (leave_ew) walk_ew_q <= 1'b0;
            end
        end
    end

    assign demand  = sensor | pend_ew_q | ped_req_ew;
    assign walk_ns = walk_ns_q;
    assign walk_ew = walk_ew_q;
`else
    logic unused_ped;
    assign unused_ped = ped_req_ns ^ ped_req_ew;
    assign demand     = sensor;
    assign walk_ns    = 1'b0;
    assign walk_ew    = 1'b0;
`endif

    assign hold = (phase_q == PH_NSG) && !demand;

    tc_phase_timer #(
        .TW        (TW),
        .RESET_VAL (NSG_LD)
    ) u_timer (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (advance),
        .load_val (load_val),
        .tick     (tick),
        .hold     (hold),
        .expire   (expire)
    );

    // NOTE: every combinational output is defaulted first so no path through the case infers a latch.
    always_comb begin
        phase_d  = phase_q;
        advance  = 1'b0;
        load_val = NSG_LD;
        case (phase_q)
            PH_NSG:  if (expire) begin phase_d = PH_NSY; advance = 1'b1; end
            PH_NSY:  if (expire) begin phase_d = PH_AR1; advance = 1'b1; end
            PH_AR1:  if (expire) begin phase_d = PH_EWG; advance = 1'b1; end
            PH_EWG:  if (expire) begin phase_d = PH_EWY; advance = 1'b1; end
            PH_EWY:  if (expire) begin phase_d = PH_AR2; advance = 1'b1; end
            PH_AR2:  if (expire) begin phase_d = PH_NSG; advance = 1'b1; end
            default: begin phase_d = PH_NSG; advance = 1'b1; end
        endcase
        case (phase_d)
            PH_NSY, PH_EWY: load_val = Y_LD;
            PH_AR1, PH_AR2: load_val = AR_LD;
            PH_EWG:         load_val = EWG_LD;
            default:        load_val = NSG_LD;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            phase_q <= PH_NSG;
            lamps_q <= lamp_vec(PH_NSG);
            start_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            lamps_q <= lamp_vec(phase_d);
            start_q <= advance;
        end
    end

    assign NS_G        = lamps_q.ns_g;
    assign NS_Y        = lamps_q.ns_y;
    assign NS_R        = lamps_q.ns_r;
    assign EW_G        = lamps_q.ew_g;
    assign EW_Y        = lamps_q.ew_y;
    assign EW_R        = lamps_q.ew_r;
    assign phase       = phase_q;
    assign phase_start = start_q;

endmodule

// File: tb/tb_tc_phase_scheduler.sv
// Self-checking bench for tc_phase_scheduler: reset/sequence vector table,
// directed corner cases and randomized stimulus against a tick-counting model.
module tb_tc_phase_scheduler;

`ifdef TC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       tick = 1'b0;
    logic       sensor = 1'b0;
    logic       ped_req_ns = 1'b0;
    logic       ped_req_ew = 1'b0;
    logic       NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R;
    logic       walk_ns, walk_ew;
    logic [2:0] phase;
    logic       phase_start;

    always #5 Clock = ~Clock;

    tc_phase_scheduler dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .tick        (tick),
        .sensor      (sensor),
        .ped_req_ns  (ped_req_ns),
        .ped_req_ew  (ped_req_ew),
        .NS_G        (NS_G),
        .NS_Y        (NS_Y),
        .NS_R        (NS_R),
        .EW_G        (EW_G),
        .EW_Y        (EW_Y),
        .EW_R        (EW_R),
        .walk_ns     (walk_ns),
        .walk_ew     (walk_ew),
        .phase       (phase),
        .phase_start (phase_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Phase durations in ticks, indexed NSG, NSY, AR1, EWG, EWY, AR2.
    int dur [6] = '{6, 2, 1, 3, 2, 1};

    // Model: phase index, ticks already spent in the phase, pedestrian state.
    int m_ph = 0;
    int m_el = 0;
    bit m_pend_ns, m_pend_ew, m_walk_ns, m_walk_ew, m_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] lamp_exp(input int ph);
        return {ph == 0, ph == 1, ph >= 2, ph == 3, ph == 4, (ph <= 2) || (ph == 5)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {phase, NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R, walk_ns, walk_ew, phase_start};
    endfunction

    function automatic logic [11:0] model_vec();
        return {3'(m_ph), lamp_exp(m_ph), m_walk_ns, m_walk_ew, m_start};
    endfunction

    task automatic model_update();
        bit demand;
        bit adv;
        int nph;
        if (!Resetn) begin
            m_ph = 0; m_el = 0; m_start = 1'b1;
            m_pend_ns = 1'b0; m_pend_ew = 1'b0; m_walk_ns = 1'b0; m_walk_ew = 1'b0;
            return;
        end
        demand = sensor | (PED & (m_pend_ew | ped_req_ew));
        adv = 1'b0;
        if (tick) begin
            if ((m_el + 1 >= dur[m_ph]) && (m_ph != 0 || demand)) adv = 1'b1;
            else m_el = (m_el + 1 < dur[m_ph]) ? m_el + 1 : dur[m_ph] - 1;
        end
        nph = adv ? (m_ph + 1) % 6 : m_ph;
        if (PED) begin
            if (adv && nph == 0) begin
                m_walk_ns = m_pend_ns | ped_req_ns; m_pend_ns = 1'b0;
            end else begin
                m_pend_ns = m_pend_ns | ped_req_ns;
                if (adv && m_ph == 0) m_walk_ns = 1'b0;
            end
            if (adv && nph == 3) begin
                m_walk_ew = m_pend_ew | ped_req_ew; m_pend_ew = 1'b0;
            end else begin
                m_pend_ew = m_pend_ew | ped_req_ew;
                if (adv && m_ph == 3) m_walk_ew = 1'b0;
            end
        end
        if (adv) m_el = 0;
        m_start = adv;
        m_ph = nph;
    endtask

    task automatic step();
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        check("cycle", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
    endtask

    typedef struct {
        bit       rst_n, tk, sens, rq_ns, rq_ew;
        bit [2:0] ph;
        bit       start;
    } vec_t;

    initial begin
        vec_t tbl [16];
        int   q_ns [$];
        int   q_nsy [$];
        int   cnt_ns, cnt_ew, steps;
        bit   found;

        tbl = '{
            '{0,0,0,0,0, 3'd0, 1},
            '{1,1,1,0,0, 3'd0, 0}, '{1,1,1,0,0, 3'd0, 0}, '{1,1,1,0,0, 3'd0, 0},
            '{1,1,1,0,0, 3'd0, 0}, '{1,1,1,0,0, 3'd0, 0},
            '{1,1,1,0,0, 3'd1, 1}, '{1,1,1,0,0, 3'd1, 0},
            '{1,1,1,0,0, 3'd2, 1},
            '{1,1,1,0,0, 3'd3, 1}, '{1,1,1,0,0, 3'd3, 0}, '{1,1,1,0,0, 3'd3, 0},
            '{1,1,1,0,0, 3'd4, 1}, '{1,1,1,0,0, 3'd4, 0},
            '{1,1,1,0,0, 3'd5, 1},
            '{1,1,1,0,0, 3'd0, 1}
        };

        @(negedge Clock);

        // Reset state and one full 15-clock period with tick and sensor high.
        for (int i = 0; i < 16; i++) begin
            Resetn = tbl[i].rst_n; tick = tbl[i].tk; sensor = tbl[i].sens;
            ped_req_ns = tbl[i].rq_ns; ped_req_ew = tbl[i].rq_ew;
            step();
            check($sformatf("table[%0d]", i),
                  {22'd0, phase, NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R, phase_start},
                  {22'd0, tbl[i].ph, lamp_exp(int'(tbl[i].ph)), tbl[i].start});
        end

        // NSG holds without demand, then leaves on the first tick that sees the sensor.
        do_reset();
        tick = 1'b1; sensor = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("hold_nsg", 32'(phase), 32'd0);
        sensor = 1'b1;
        step();
        check("sensor_exit_nsy", 32'(NS_Y), 32'd1);

        // Single ped_req_ew pulse with no sensor releases NSG and lights walk_ew for EWG only.
        do_reset();
        tick = 1'b1; sensor = 1'b0;
        for (int i = 0; i < 10; i++) step();
        ped_req_ew = 1'b1;
        step();
        ped_req_ew = 1'b0;
        check("ped_ew_exit", 32'(phase), PED ? 32'd1 : 32'd0);
        cnt_ns = 0; cnt_ew = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (walk_ew === 1'b1) cnt_ew++;
            if (walk_ns === 1'b1) cnt_ns++;
        end
        check("walk_ew_clocks", 32'(cnt_ew), PED ? 32'd3 : 32'd0);
        check("walk_ns_idle", 32'(cnt_ns), 32'd0);

        // ped_req_ns during an NSG without walk waits for the next NSG entry.
        do_reset();
        tick = 1'b1; sensor = 1'b0;
        for (int i = 0; i < 8; i++) step();
        ped_req_ns = 1'b1;
        step();
        ped_req_ns = 1'b0;
        cnt_ns = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (walk_ns === 1'b1) cnt_ns++;
        end
        check("walk_ns_not_current", 32'(cnt_ns), 32'd0);
        sensor = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (phase_start === 1'b1 && phase === 3'd0) found = 1'b1;
        end
        check("ns_reentry_found", 32'(found), 32'd1);
        check("walk_ns_next_nsg", 32'(walk_ns), 32'(PED));

        // Tick on every second clock doubles all phase lengths.
        do_reset();
        sensor = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick = (c % 2 == 1);
            step();
            if (phase_start === 1'b1 && phase === 3'd0) q_ns.push_back(c);
            if (phase_start === 1'b1 && phase === 3'd1) q_nsy.push_back(c);
        end
        check("tick2_enough_periods", 32'(q_ns.size() >= 3), 32'd1);
        if (q_ns.size() >= 3) begin
            check("tick2_period", 32'(q_ns[2] - q_ns[1]), 32'd30);
            found = 1'b0;
            foreach (q_nsy[k]) begin
                if (!found && q_nsy[k] > q_ns[1]) begin
                    check("tick2_nsg_len", 32'(q_nsy[k] - q_ns[1]), 32'd12);
                    found = 1'b1;
                end
            end
            check("tick2_nsy_seen", 32'(found), 32'd1);
        end

        // Reset during EWG with a pending NS request clears everything.
        do_reset();
        tick = 1'b1; sensor = 1'b1;
        for (int i = 0; i < 7; i++) step();
        ped_req_ns = 1'b1;
        step();
        ped_req_ns = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (phase === 3'd3) found = 1'b1;
        end
        check("reach_ewg", 32'(found), 32'd1);
        step();
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        check("rst_mid_state", {23'd0, phase, NS_G, EW_R, walk_ns, phase_start, NS_Y},
                               {23'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        steps = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            steps++;
            if (phase === 3'd1) found = 1'b1;
        end
        check("rst_timer_nsg_len", 32'(steps), 32'd6);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (phase_start === 1'b1 && phase === 3'd0) found = 1'b1;
        end
        check("rst_pend_cleared", {31'd0, found & ~walk_ns}, 32'd1);

        // Randomized traffic, buttons, ticks and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            Resetn     = ($urandom_range(0, 199) != 0);
            tick       = $urandom_range(0, 1) == 1;
            sensor     = $urandom_range(0, 3) == 0;
            ped_req_ns = $urandom_range(0, 9) == 0;
            ped_req_ew = $urandom_range(0, 9) == 0;
            step();
        end
        Resetn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
